// File: rtl/memwb_pkg.sv
// Shared types for the MEM/WB stage: default field widths, payload layout, handshake states.
// The payload struct uses the default widths; the top re-derives it when overridden.
package memwb_pkg;

  localparam int MEMWB_DATA_W     = 16;
  localparam int MEMWB_REG_ADDR_W = 4;

  typedef struct packed {
    logic                        ret;
    logic                        mem_to_reg;
    logic                        reg_write;
    logic [MEMWB_REG_ADDR_W-1:0] reg_rd;
    logic [MEMWB_DATA_W-1:0]     mem_read_data;
    logic [MEMWB_DATA_W-1:0]     alu_result;
  } memwb_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready stage with head register and optional skid entry; 1-cycle latency.
// SKID=1: in_ready decoded from state only; SKID=0: in_ready = ~out_valid | out_ready.
module pipe_skid_buf
  import memwb_pkg::*;
#(
  parameter type T    = memwb_payload_t,
  parameter bit  SKID = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  stage_state_e state;
  stage_state_e state_nxt;
  T             head;
  T             skid;
  logic         accept;
  logic         consume;
  logic         head_load;
  logic         skid_load;
  logic         head_from_skid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (consume && !accept)      state_nxt = ST_EMPTY;
          else if (accept && !consume) state_nxt = SKID ? ST_TWO : ST_ONE;
        end
        ST_TWO:   if (consume) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != ST_EMPTY);
    if (SKID) in_ready = (state != ST_TWO);
    else      in_ready = (state == ST_EMPTY) || out_ready;
  end

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // Skid only ever holds the entry directly behind head, so a drain of TWO promotes it.
  assign head_load      = accept & ((state == ST_EMPTY) | ((state == ST_ONE) & consume));
  assign skid_load      = SKID & accept & (state == ST_ONE) & ~consume;
  assign head_from_skid = (state == ST_TWO) & consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      skid <= '0;
    end else if (!flush) begin
      if (head_from_skid) head <= skid;
      else if (head_load) head <= in_data;
      if (skid_load)      skid <= in_data;
    end
  end

  assign out_data = head;

endmodule

// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline register with valid/ready, optional skid, flush; payload visible 1 cycle after accept.
// Back-pressure from WB holds outputs stable; wb_data is muxed from registered head fields.
module memwb_pipe_stage
  import memwb_pkg::*;
#(
  parameter int DATA_W     = MEMWB_DATA_W,
  parameter int REG_ADDR_W = MEMWB_REG_ADDR_W,
  parameter bit SKID       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  ret_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic [REG_ADDR_W-1:0] reg_rd_in,
  input  logic [DATA_W-1:0]     mem_read_data_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ret_out,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic [REG_ADDR_W-1:0] reg_rd_out,
  output logic [DATA_W-1:0]     mem_read_data_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     wb_data_out
);

  // Same layout as memwb_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  ret;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] reg_rd;
    logic [DATA_W-1:0]     mem_read_data;
    logic [DATA_W-1:0]     alu_result;
  } payload_t;

  payload_t in_pl;
  payload_t head_pl;

  assign in_pl.ret           = ret_in;
  assign in_pl.mem_to_reg    = mem_to_reg_in;
  assign in_pl.reg_write     = reg_write_in;
  assign in_pl.reg_rd        = reg_rd_in;
  assign in_pl.mem_read_data = mem_read_data_in;
  assign in_pl.alu_result    = alu_result_in;

  pipe_skid_buf #(
    .T    (payload_t),
    .SKID (SKID)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_pl)
  );

  assign ret_out           = head_pl.ret;
  assign mem_to_reg_out    = head_pl.mem_to_reg;
  assign reg_rd_out        = head_pl.reg_rd;
  assign mem_read_data_out = head_pl.mem_read_data;
  assign alu_result_out    = head_pl.alu_result;
  // A flushed head may keep stale fields, so the write strobe is gated by valid.
  assign reg_write_out     = out_valid & head_pl.reg_write;
  assign wb_data_out       = head_pl.mem_to_reg ? head_pl.mem_read_data : head_pl.alu_result;

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// Bench for memwb_pipe_stage: SKID=1 instance (a_*) and SKID=0 instance (b_*) against a queue model.
module tb_memwb_pipe_stage;
  import memwb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  typedef logic [56:0] obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  memwb_payload_t a_in, b_in;
  logic a_ret, a_m2r, a_rw, b_ret, b_m2r, b_rw;
  logic [AW-1:0] a_rd, b_rd;
  logic [DW-1:0] a_mrd, a_alu, a_wb, b_mrd, b_alu, b_wb;
  obs_t a_obs, b_obs;

  assign a_obs = {a_in_ready, a_out_valid, a_rw, a_ret, a_m2r, a_rd, a_mrd, a_alu, a_wb};
  assign b_obs = {b_in_ready, b_out_valid, b_rw, b_ret, b_m2r, b_rd, b_mrd, b_alu, b_wb};

  memwb_pipe_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .SKID(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ret_in(a_in.ret), .mem_to_reg_in(a_in.mem_to_reg), .reg_write_in(a_in.reg_write),
    .reg_rd_in(a_in.reg_rd), .mem_read_data_in(a_in.mem_read_data), .alu_result_in(a_in.alu_result),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .ret_out(a_ret), .mem_to_reg_out(a_m2r),
    .reg_write_out(a_rw), .reg_rd_out(a_rd), .mem_read_data_out(a_mrd), .alu_result_out(a_alu),
    .wb_data_out(a_wb)
  );

  memwb_pipe_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .SKID(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ret_in(b_in.ret), .mem_to_reg_in(b_in.mem_to_reg), .reg_write_in(b_in.reg_write),
    .reg_rd_in(b_in.reg_rd), .mem_read_data_in(b_in.mem_read_data), .alu_result_in(b_in.alu_result),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .ret_out(b_ret), .mem_to_reg_out(b_m2r),
    .reg_write_out(b_rw), .reg_rd_out(b_rd), .mem_read_data_out(b_mrd), .alu_result_out(b_alu),
    .wb_data_out(b_wb)
  );

  // Model: a FIFO of capacity 2 (a) or 1 with pass-through ready (b); z* = data still at reset value.
  memwb_payload_t qa[$];
  memwb_payload_t qb[$];
  bit za, zb;
  int ncmp = 0;
  int nerr = 0;

  function automatic bit rdy_a();
    return qa.size() < 2;
  endfunction

  function automatic bit rdy_b();
    return (qb.size() == 0) || b_out_ready;
  endfunction

  function automatic obs_t exp_vec(bit rdy, bit vld, memwb_payload_t p);
    logic [DW-1:0] wb;
    wb = p.mem_to_reg ? p.mem_read_data : p.alu_result;
    return {rdy, vld, vld & p.reg_write, p.ret, p.mem_to_reg, p.reg_rd, p.mem_read_data, p.alu_result, wb};
  endfunction

  function automatic obs_t mask_of(bit vld, bit z);
    if (vld || z) return '1;
    return {3'b111, 54'd0};
  endfunction

  function automatic obs_t exp_a();
    memwb_payload_t p;
    p = (qa.size() > 0) ? qa[0] : '0;
    return exp_vec(rdy_a(), qa.size() > 0, p);
  endfunction

  function automatic obs_t exp_b();
    memwb_payload_t p;
    p = (qb.size() > 0) ? qb[0] : '0;
    return exp_vec(rdy_b(), qb.size() > 0, p);
  endfunction

  function automatic memwb_payload_t rnd_pl();
    memwb_payload_t p;
    p.ret           = 1'($urandom_range(0, 1));
    p.mem_to_reg    = 1'($urandom_range(0, 1));
    p.reg_write     = 1'($urandom_range(0, 1));
    p.reg_rd        = 4'($urandom_range(0, 15));
    p.mem_read_data = 16'($urandom_range(0, 65535));
    p.alu_result    = 16'($urandom_range(0, 65535));
    return p;
  endfunction

  // Advance model and DUT by one clock; model uses only bench inputs and its own queues.
  task automatic tick();
    bit acc_a, con_a, acc_b, con_b;
    @(posedge clk);
    acc_a = a_in_valid && rdy_a();
    con_a = (qa.size() > 0) && a_out_ready;
    acc_b = b_in_valid && rdy_b();
    con_b = (qb.size() > 0) && b_out_ready;
    if (rst) begin
      qa.delete(); qb.delete(); za = 1'b1; zb = 1'b1;
    end else begin
      if (a_flush) qa.delete();
      else begin
        if (con_a) void'(qa.pop_front());
        if (acc_a) begin qa.push_back(a_in); za = 1'b0; end
      end
      if (b_flush) qb.delete();
      else begin
        if (con_b) void'(qb.pop_front());
        if (acc_b) begin qb.push_back(b_in); zb = 1'b0; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    obs_t ea, ma;
    rst = 1'b1;
    a_in_valid = 1'b1; a_in = rnd_pl();
    b_in_valid = 1'b1; b_in = rnd_pl();
    tick(); tick();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    ncmp++;
    if (a_obs !== {1'b1, 56'd0}) begin
      $display("FAIL reset_a: got %h expected %h", a_obs, {1'b1, 56'd0}); nerr++;
    end
    ncmp++;
    if (b_obs !== {1'b1, 56'd0}) begin
      $display("FAIL reset_b: got %h expected %h", b_obs, {1'b1, 56'd0}); nerr++;
    end
    ea = exp_a(); ma = mask_of(qa.size() > 0, za);
    ncmp++;
    if ((a_obs & ma) !== (ea & ma)) begin
      $display("FAIL reset_model: got %h expected %h", a_obs, ea); nerr++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    obs_t ea, ma;
    a_out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        a_in_valid = 1'b1; a_in = rnd_pl(); a_in.alu_result = 16'(i + 1);
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        ncmp++;
        if (a_out_valid !== 1'b1 || a_alu !== 16'(i) || a_in_ready !== 1'b1) begin
          $display("FAIL stream_%0d: got vld=%b alu=%h rdy=%b expected vld=1 alu=%h rdy=1",
                   i, a_out_valid, a_alu, a_in_ready, 16'(i));
          nerr++;
        end
      end
      ea = exp_a(); ma = mask_of(qa.size() > 0, za);
      ncmp++;
      if ((a_obs & ma) !== (ea & ma)) begin
        $display("FAIL stream_model_%0d: got %h expected %h", i, a_obs, ea); nerr++;
      end
      tick();
    end
    ncmp++;
    if (a_out_valid !== 1'b0) begin
      $display("FAIL stream_drain: got vld=%b expected 0", a_out_valid); nerr++;
    end
  endtask

  task automatic test_skid();
    logic [DW-1:0] want [3];
    obs_t ea, ma;
    want[0] = 16'h00AA; want[1] = 16'h00BB; want[2] = 16'h00CC;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in = rnd_pl(); a_in.alu_result = want[0];
    tick();
    a_in = rnd_pl(); a_in.alu_result = want[1];
    tick();
    a_in = rnd_pl(); a_in.alu_result = want[2];
    #1;
    ncmp++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_alu !== want[0]) begin
      $display("FAIL skid_full: got rdy=%b vld=%b alu=%h expected rdy=0 vld=1 alu=%h",
               a_in_ready, a_out_valid, a_alu, want[0]);
      nerr++;
    end
    tick();
    ncmp++;
    if (a_in_ready !== 1'b0 || a_alu !== want[0]) begin
      $display("FAIL skid_hold: got rdy=%b alu=%h expected rdy=0 alu=%h", a_in_ready, a_alu, want[0]);
      nerr++;
    end
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      ncmp++;
      if (a_out_valid !== 1'b1 || a_alu !== want[k]) begin
        $display("FAIL skid_drain_%0d: got vld=%b alu=%h expected vld=1 alu=%h",
                 k, a_out_valid, a_alu, want[k]);
        nerr++;
      end
      ea = exp_a(); ma = mask_of(qa.size() > 0, za);
      ncmp++;
      if ((a_obs & ma) !== (ea & ma)) begin
        $display("FAIL skid_model_%0d: got %h expected %h", k, a_obs, ea); nerr++;
      end
      tick();
      if (!rdy_a() || a_in_ready !== 1'b0) a_in_valid = a_in_valid;
      if (k == 1) a_in_valid = 1'b0;
    end
    #1;
    ncmp++;
    if (a_out_valid !== 1'b0) begin
      $display("FAIL skid_empty: got vld=%b expected 0", a_out_valid); nerr++;
    end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in = rnd_pl(); a_in.reg_write = 1'b1;
    tick(); tick();
    a_flush = 1'b1; a_in = rnd_pl(); a_in.alu_result = 16'hDEAD;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    ncmp++;
    if (a_out_valid !== 1'b0 || a_rw !== 1'b0 || a_in_ready !== 1'b1) begin
      $display("FAIL flush_two: got vld=%b rw=%b rdy=%b expected vld=0 rw=0 rdy=1",
               a_out_valid, a_rw, a_in_ready);
      nerr++;
    end
    // Flush from empty with in_ready=1: the offered payload still must not land.
    a_flush = 1'b1; a_in_valid = 1'b1; a_in.reg_write = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      ncmp++;
      if (a_out_valid !== 1'b0 || a_rw !== 1'b0) begin
        $display("FAIL flush_empty_%0d: got vld=%b rw=%b expected vld=0 rw=0", k, a_out_valid, a_rw);
        nerr++;
      end
      tick();
    end
  endtask

  task automatic test_wb_select();
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    a_in.ret = 1'b1; a_in.mem_to_reg = 1'b1; a_in.reg_write = 1'b1; a_in.reg_rd = 4'hF;
    a_in.mem_read_data = 16'hBEEF; a_in.alu_result = 16'h1234;
    tick();
    a_in.mem_to_reg = 1'b0;
    #1;
    ncmp++;
    if (a_wb !== 16'hBEEF || a_ret !== 1'b1 || a_rd !== 4'hF || a_rw !== 1'b1) begin
      $display("FAIL wb_mem: got wb=%h ret=%b rd=%h rw=%b expected wb=beef ret=1 rd=f rw=1",
               a_wb, a_ret, a_rd, a_rw);
      nerr++;
    end
    tick();
    a_in_valid = 1'b0;
    #1;
    ncmp++;
    if (a_wb !== 16'h1234 || a_m2r !== 1'b0) begin
      $display("FAIL wb_alu: got wb=%h m2r=%b expected wb=1234 m2r=0", a_wb, a_m2r);
      nerr++;
    end
    tick();
  endtask

  task automatic test_random_skid1();
    obs_t ea, ma;
    for (int c = 0; c < 3000; c++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in        = rnd_pl();
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_flush     = ($urandom_range(0, 31) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      #1;
      ea = exp_a(); ma = mask_of(qa.size() > 0, za);
      ncmp++;
      if ((a_obs & ma) !== (ea & ma)) begin
        $display("FAIL rand_a_%0d: got %h expected %h", c, a_obs, ea); nerr++;
      end
      tick();
    end
    rst = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_skid0();
    obs_t eb, mb;
    for (int c = 0; c < 10000; c++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in        = rnd_pl();
      b_out_ready = 1'($urandom_range(0, 1));
      b_flush     = ($urandom_range(0, 127) == 0);
      #1;
      eb = exp_b(); mb = mask_of(qb.size() > 0, zb);
      ncmp++;
      if ((b_obs & mb) !== (eb & mb)) begin
        $display("FAIL skid0_%0d: got %h expected %h", c, b_obs, eb); nerr++;
      end
      tick();
    end
    b_flush = 1'b0; b_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in = '0;
    za = 1'b1; zb = 1'b1;
    #2;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_wb_select();
    test_random_skid1();
    test_skid0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
